// File: rtl/branch_redirect_unit.sv
// Execute-stage branch resolution: mispredict redirect to the IFU, IF/ID flush, EX stall
// and misaligned-target trap. Define BRANCH_STATS_EN to build the statistics counters.
module branch_redirect_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             branch_control,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_o,
  output logic             ex_stall_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  trap_tval,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  typedef enum logic [1:0] {IDLE, REDIRECT, TRAP} state_t;

  state_t            state;
  logic              resolve;
  logic              taken;
  logic              mispredict;
  logic              misalign;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   next_pc;

  // Resolution only happens in IDLE; instructions presented during REDIRECT/TRAP are ignored.
  assign resolve    = (state == IDLE) && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
  assign taken      = (ex_is_branch && branch_control) || ex_is_jal || ex_is_jalr;
  assign target     = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);
  assign next_pc    = taken ? target : (ex_pc + XLEN'(4));
  assign misalign   = resolve && taken && target[1];
  assign mispredict = resolve && (ex_is_jalr || (taken != ex_pred_taken));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_o        <= 1'b0;
      ex_stall_o     <= 1'b0;
      trap_o         <= 1'b0;
      trap_tval      <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are overridden below; with non-blocking
      // assignments the last write in the block wins, so no pulse can stick high.
      flush_o <= 1'b0;
      trap_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (misalign) begin
            state     <= TRAP;
            trap_o    <= 1'b1;
            trap_tval <= target;
            flush_o   <= 1'b1;
          end else if (mispredict) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= next_pc;
            flush_o        <= 1'b1;
            ex_stall_o     <= 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            ex_stall_o     <= 1'b0;
          end
        end
        TRAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && !misalign) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = mispredict_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a behavioural model.
module tb_branch_redirect_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  typedef enum int {K_NONE, K_REDIR, K_TRAP} kind_t;

  typedef struct {
    logic [2:0]      cls;   // one-hot {jalr, jal, branch}
    logic            bc;
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    kind_t           kind;
    logic [XLEN-1:0] val;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_is_branch = 1'b0;
  logic             ex_is_jal = 1'b0;
  logic             ex_is_jalr = 1'b0;
  logic             branch_control = 1'b0;
  logic             ex_pred_taken = 1'b0;
  logic [XLEN-1:0]  ex_pc = '0;
  logic [XLEN-1:0]  ex_imm = '0;
  logic [XLEN-1:0]  ex_rs1 = '0;
  logic             redirect_ready = 1'b0;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_o;
  logic             ex_stall_o;
  logic             trap_o;
  logic [XLEN-1:0]  trap_tval;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mis  = 0;

  always #5 clk = ~clk;

  branch_redirect_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .branch_control(branch_control),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_o(flush_o), .ex_stall_o(ex_stall_o),
    .trap_o(trap_o), .trap_tval(trap_tval), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the architectural outcome of one control-flow instruction.
  function automatic void model(input vec_t v, output kind_t kind, output logic [XLEN-1:0] val);
    bit              is_jalr = v.cls[2];
    bit              is_take;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] sum;
    is_take = v.cls[2] || v.cls[1] || (v.cls[0] && v.bc);
    sum     = v.rs1 + v.imm;
    tgt     = is_jalr ? (sum - (sum % 2)) : (v.pc + v.imm);
    if (is_take && (tgt % 4) >= 2) begin
      kind = K_TRAP;  val = tgt;
    end else if (is_jalr || (is_take != v.pred)) begin
      kind = K_REDIR; val = is_take ? tgt : v.pc + 4;
    end else begin
      kind = K_NONE;  val = '0;
    end
  endfunction

  task automatic drive(input vec_t v);
    ex_is_branch   = v.cls[0];
    ex_is_jal      = v.cls[1];
    ex_is_jalr     = v.cls[2];
    branch_control = v.bc;
    ex_pred_taken  = v.pred;
    ex_pc          = v.pc;
    ex_imm         = v.imm;
    ex_rs1         = v.rs1;
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, " stat_branches"},    64'(stat_branches),    64'(exp_br));
    check({tag, " stat_mispredicts"}, 64'(stat_mispredicts), 64'(exp_mis));
`else
    check({tag, " stat_branches"},    64'(stat_branches),    64'd0);
    check({tag, " stat_mispredicts"}, 64'(stat_mispredicts), 64'd0);
`endif
  endtask

  // Issue one instruction from IDLE; hold ready low for 'delay' redirect cycles.
  task automatic issue(input string name, input vec_t v, input int delay);
    @(negedge clk);
    drive(v);
    ex_valid       = 1'b1;
    redirect_ready = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    exp_br++;
    case (v.kind)
      K_NONE: begin
        check({name, " valid"}, 64'(redirect_valid), 64'd0);
        check({name, " flush"}, 64'(flush_o),        64'd0);
        check({name, " trap"},  64'(trap_o),         64'd0);
        check({name, " stall"}, 64'(ex_stall_o),     64'd0);
      end
      K_REDIR: begin
        exp_mis++;
        check({name, " valid"}, 64'(redirect_valid), 64'd1);
        check({name, " pc"},    64'(redirect_pc),    64'(v.val));
        check({name, " flush"}, 64'(flush_o),        64'd1);
        check({name, " stall"}, 64'(ex_stall_o),     64'd1);
        check({name, " trap"},  64'(trap_o),         64'd0);
        for (int k = 0; k < delay; k++) begin
          @(negedge clk);
          check({name, " hold valid"}, 64'(redirect_valid), 64'd1);
          check({name, " hold pc"},    64'(redirect_pc),    64'(v.val));
          check({name, " hold flush"}, 64'(flush_o),        64'd0);
          check({name, " hold stall"}, 64'(ex_stall_o),     64'd1);
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        check({name, " drop valid"}, 64'(redirect_valid), 64'd0);
        check({name, " drop stall"}, 64'(ex_stall_o),     64'd0);
      end
      K_TRAP: begin
        check({name, " trap"},  64'(trap_o),         64'd1);
        check({name, " tval"},  64'(trap_tval),      64'(v.val));
        check({name, " flush"}, 64'(flush_o),        64'd1);
        check({name, " valid"}, 64'(redirect_valid), 64'd0);
        check({name, " stall"}, 64'(ex_stall_o),     64'd0);
        @(negedge clk);
        check({name, " trap end"},  64'(trap_o),    64'd0);
        check({name, " flush end"}, 64'(flush_o),   64'd0);
        check({name, " tval held"}, 64'(trap_tval), 64'(v.val));
      end
      default: ;
    endcase
  endtask

  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t w;
    kind_t k;
    logic [XLEN-1:0] val;

    //           cls     bc    pred  pc             imm            rs1            kind     val
    tbl[0]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'h0,         K_REDIR, 32'h0000_0120};
    tbl[1]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0040, 32'h0,         K_REDIR, 32'h0000_0204};
    tbl[2]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0040, 32'h0,         K_NONE,  32'h0};
    tbl[3]  = '{3'b001, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0010, 32'h0,         K_NONE,  32'h0};
    tbl[4]  = '{3'b100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_1003, K_TRAP,  32'h0000_1006};
    tbl[5]  = '{3'b100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_1000, K_REDIR, 32'h0000_1004};
    tbl[6]  = '{3'b010, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0100, 32'h0,         K_NONE,  32'h0};
    tbl[7]  = '{3'b010, 1'b0, 1'b0, 32'h0000_0400, 32'hFFFF_FFF8, 32'h0,         K_REDIR, 32'h0000_03F8};
    tbl[8]  = '{3'b001, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0006, 32'h0,         K_TRAP,  32'h0000_0506};
    tbl[9]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0006, 32'h0,         K_NONE,  32'h0};
    tbl[10] = '{3'b010, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         K_REDIR, 32'h0000_0010};
    tbl[11] = '{3'b100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1001, K_REDIR, 32'h0000_1000};

    // Reset state
    #12;
    check("reset valid", 64'(redirect_valid), 64'd0);
    check("reset pc",    64'(redirect_pc),    64'd0);
    check("reset flush", 64'(flush_o),        64'd0);
    check("reset stall", 64'(ex_stall_o),     64'd0);
    check("reset trap",  64'(trap_o),         64'd0);
    check("reset tval",  64'(trap_tval),      64'd0);
    check_stats("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no instruction and a stray ready: nothing happens
    @(negedge clk);
    redirect_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_ready = 1'b0;
    check("idle ready valid", 64'(redirect_valid), 64'd0);
    check("idle ready flush", 64'(flush_o),        64'd0);
    check("idle ready stall", 64'(ex_stall_o),     64'd0);

    // Directed table
    for (int i = 0; i < 12; i++) issue($sformatf("vec%0d", i), tbl[i], i % 3);
    check_stats("table");

    // Redirect held 3 cycles with a second instruction presented, which must be ignored
    @(negedge clk);
    drive(tbl[0]);
    ex_valid = 1'b1;
    @(negedge clk);
    w = '{3'b010, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_0040, 32'h0, K_REDIR, 32'h0};
    drive(w);
    check("hold first flush", 64'(flush_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold valid", 64'(redirect_valid), 64'd1);
      check("hold pc",    64'(redirect_pc),    64'h120);
      check("hold stall", 64'(ex_stall_o),     64'd1);
      check("hold flush", 64'(flush_o),        64'd0);
    end
    ex_valid       = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check("hold exit valid", 64'(redirect_valid), 64'd0);
    @(negedge clk);
    check("ignored no valid", 64'(redirect_valid), 64'd0);
    check("ignored no flush", 64'(flush_o),        64'd0);
    exp_br++;
    exp_mis++;
    check_stats("hold");

    // Asynchronous reset in the middle of a redirect
    @(negedge clk);
    drive(tbl[1]);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    check("prereset valid", 64'(redirect_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async valid", 64'(redirect_valid), 64'd0);
    check("async pc",    64'(redirect_pc),    64'd0);
    check("async stall", 64'(ex_stall_o),     64'd0);
    check("async flush", 64'(flush_o),        64'd0);
    exp_br  = 0;
    exp_mis = 0;
    check_stats("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release valid", 64'(redirect_valid), 64'd0);
    check("release flush", 64'(flush_o),        64'd0);
    check("release stall", 64'(ex_stall_o),     64'd0);
    issue("post reset", tbl[0], 0);

    // Randomized instructions against the model
    for (int n = 0; n < 300; n++) begin
      v.cls  = 3'b001 << $urandom_range(0, 2);
      v.bc   = 1'($urandom);
      v.pred = v.cls[2] ? 1'b0 : 1'($urandom);
      v.pc   = $urandom & 32'hFFFF_FFFC;
      v.imm  = v.cls[2] ? $urandom : ($urandom & 32'hFFFF_FFFE);
      v.rs1  = $urandom;
      model(v, k, val);
      v.kind = k;
      v.val  = val;
      issue($sformatf("rand%0d", n), v, int'($urandom_range(0, 3)));
    end
    check_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
